// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline types: fetch/decode payload, skid-stage state encoding
// and the canonical NOP used as the decode-side reset instruction.
package rv32_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage with a two-entry skid buffer so in_ready is a register.
// Optional decode stall counter is built when IF_ID_PERF_CNT_EN is defined.
module if_id_skid_stage
    import rv32_pipe_pkg::*;
#(
    parameter int XLEN = rv32_pipe_pkg::XLEN,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0]     perf_stall_cnt,
`endif
    output skid_state_t     dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and ready is purely registered.
    skid_state_t     state_q, state_d;
    logic            in_ready_q, out_valid_q;
    logic [XLEN-1:0] main_pc_q, skid_pc_q;
    logic [ILEN-1:0] main_instr_q, skid_instr_q;
    logic            in_fire, out_fire;
    logic            load_main_in, load_main_skid, load_skid;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_d      = FULL;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = SKID;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Redirect wins over any handshake; the fetched entry is dropped.
        if (flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= ILEN'(NOP_INSTR);
            skid_pc_q    <= '0;
            skid_instr_q <= ILEN'(NOP_INSTR);
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != SKID);
            out_valid_q <= (state_d != EMPTY);
            if (load_main_in) begin
                main_pc_q    <= in_pc;
                main_instr_q <= in_instr;
            end else if (load_main_skid) begin
                main_pc_q    <= skid_pc_q;
                main_instr_q <= skid_instr_q;
            end
            if (load_skid) begin
                skid_pc_q    <= in_pc;
                skid_instr_q <= in_instr;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;
    assign dbg_state = state_q;

`ifdef IF_ID_PERF_CNT_EN
    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid_q && !out_ready && !flush),
        .count (perf_stall_cnt)
    );
`endif

endmodule
